// File: rtl/cpu_pkg.sv
// Shared definitions between the control unit and the datapath.
// Covers ALU opcodes, B-bus source codes and FLAGS/FLAGC bit positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        AluZero,
        AluAdd,
        AluSub,
        AluPassB,
        AluShl1,
        AluShl2,
        AluShr1,
        AluShr2
    } alu_op_e;

    typedef enum logic [2:0] {
        BusPc,
        BusR1,
        BusR2,
        BusTr,
        BusR,
        BusAc,
        BusDm,
        BusIm
    } bus_src_e;

    localparam int unsigned FsPci = 5;
    localparam int unsigned FsR1i = 4;
    localparam int unsigned FsR2i = 3;
    localparam int unsigned FsAri = 2;
    localparam int unsigned FsFet = 1;
    localparam int unsigned FsFin = 0;

    localparam int unsigned FcAr   = 7;
    localparam int unsigned FcPc   = 6;
    localparam int unsigned FcR1   = 5;
    localparam int unsigned FcR2   = 4;
    localparam int unsigned FcTr   = 3;
    localparam int unsigned FcR    = 2;
    localparam int unsigned FcAc   = 1;
    localparam int unsigned FcDmwr = 0;

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU: A is the accumulator, B is the shared bus.
module alu_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        OP,
    output logic [DATA_W-1:0] C
);

    always_comb begin
        C = '0;
        unique case (alu_op_e'(OP))
            AluZero:  C = '0;
            AluAdd:   C = A + B;
            AluSub:   C = A - B;
            AluPassB: C = B;
            AluShl1:  C = A << 1;
            AluShl2:  C = A << 2;
            AluShr1:  C = A >> 1;
            AluShr2:  C = A >> 2;
            default:  C = '0;
        endcase
    end

endmodule

// File: rtl/datapath_core.sv
// Register-and-bus datapath executing one control word per cycle.
// Holds PC, AR, R1, R2, TR, R, AC, IR, Z and a sticky halt flag.
module datapath_core
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [5:0]        FLAGS,
    input  logic [2:0]        FLAGB,
    input  logic [2:0]        ALU,
    input  logic [7:0]        FLAGC,
    output logic [ADDR_W-1:0] IM_ADDR,
    input  logic [DATA_W-1:0] IM_RDATA,
    output logic [ADDR_W-1:0] DM_ADDR,
    input  logic [DATA_W-1:0] DM_RDATA,
    output logic [DATA_W-1:0] DM_WDATA,
    output logic              DM_WE,
    output logic [DATA_W-1:0] IR,
    output logic              FLAGZ,
    output logic              HALTED,
    output logic [15:0]       FETCH_COUNT
);

    logic [DATA_W-1:0] pc_q, ar_q, r1_q, r2_q, tr_q, r_q, ac_q, ir_q;
    logic              flagz_q, halted_q;
    logic [15:0]       fetch_count_q;
    logic [DATA_W-1:0] bus_b;
    logic [DATA_W-1:0] alu_c;

    always_comb begin
        bus_b = '0;
        unique case (bus_src_e'(FLAGB))
            BusPc:   bus_b = pc_q;
            BusR1:   bus_b = r1_q;
            BusR2:   bus_b = r2_q;
            BusTr:   bus_b = tr_q;
            BusR:    bus_b = r_q;
            BusAc:   bus_b = ac_q;
            BusDm:   bus_b = DM_RDATA;
            BusIm:   bus_b = IM_RDATA;
            default: bus_b = '0;
        endcase
    end

    alu_unit #(
        .DATA_W(DATA_W)
    ) u_alu (
        .A (ac_q),
        .B (bus_b),
        .OP(ALU),
        .C (alu_c)
    );

    // Load beats increment; the word carrying FIN still executes in full.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pc_q          <= '0;
            ar_q          <= '0;
            r1_q          <= '0;
            r2_q          <= '0;
            tr_q          <= '0;
            r_q           <= '0;
            ac_q          <= '0;
            ir_q          <= '0;
            flagz_q       <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else if (!halted_q) begin
            if (FLAGC[FcPc])        pc_q <= bus_b;
            else if (FLAGS[FsPci])  pc_q <= pc_q + 1'b1;

            if (FLAGC[FcAr])        ar_q <= bus_b;
            else if (FLAGS[FsAri])  ar_q <= ar_q + 1'b1;

            if (FLAGC[FcR1])        r1_q <= bus_b;
            else if (FLAGS[FsR1i])  r1_q <= r1_q + 1'b1;

            if (FLAGC[FcR2])        r2_q <= bus_b;
            else if (FLAGS[FsR2i])  r2_q <= r2_q + 1'b1;

            if (FLAGC[FcTr]) tr_q <= bus_b;
            if (FLAGC[FcR])  r_q  <= bus_b;

            if (FLAGC[FcAc]) begin
                ac_q    <= alu_c;
                flagz_q <= (alu_c == '0);
            end

            if (FLAGS[FsFet]) begin
                ir_q <= IM_RDATA;
                if (fetch_count_q != 16'hFFFF) fetch_count_q <= fetch_count_q + 16'd1;
            end

            if (FLAGS[FsFin]) halted_q <= 1'b1;
        end
    end

    assign IM_ADDR     = pc_q[ADDR_W-1:0];
    assign DM_ADDR     = ar_q[ADDR_W-1:0];
    assign DM_WDATA    = ac_q;
    assign DM_WE       = FLAGC[FcDmwr] & ~halted_q;
    assign IR          = ir_q;
    assign FLAGZ       = flagz_q;
    assign HALTED      = halted_q;
    assign FETCH_COUNT = fetch_count_q;

endmodule
